// File: rtl/sd_mac_pkg.sv
// rtl/sd_mac_pkg.sv - shared types and constants for the vedic MAC sequencer
package sd_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_LEN_W = 8;
    localparam int DEF_ACC_W = 24;
    localparam int PROD_W    = 16;

endpackage

// File: rtl/SD_vedic_8X8.sv
// rtl/SD_vedic_8X8.sv - combinational 8x8 unsigned vedic (urdhva-tiryak) multiplier
module SD_vedic_8X8
    import sd_mac_pkg::*;
(
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic [PROD_W-1:0] p
);

    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic c;
        logic [3:0] r;
        c    = x[1] & y[0] & x[0] & y[1];
        r[0] = x[0] & y[0];
        r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        r[2] = (x[1] & y[1]) ^ c;
        r[3] = x[1] & y[1] & c;
        return r;
    endfunction

    // Each level combines four half-width partials: low, two cross terms, high.
    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        logic [4:0] mid;
        q0  = v2(x[1:0], y[1:0]);
        q1  = v2(x[3:2], y[1:0]);
        q2  = v2(x[1:0], y[3:2]);
        q3  = v2(x[3:2], y[3:2]);
        mid = {1'b0, q1} + {1'b0, q2};
        return {4'b0, q0} + {1'b0, mid, 2'b0} + {q3, 4'b0};
    endfunction

    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;

    always_comb begin
        q0  = v4(a[3:0], b[3:0]);
        q1  = v4(a[7:4], b[3:0]);
        q2  = v4(a[3:0], b[7:4]);
        q3  = v4(a[7:4], b[7:4]);
        mid = {1'b0, q1} + {1'b0, q2};
        p   = {8'b0, q0} + {3'b0, mid, 4'b0} + {q3, 8'b0};
    end

endmodule

// File: rtl/sd_vedic_mac_seq.sv
// rtl/sd_vedic_mac_seq.sv - burst dot-product sequencer around one SD_vedic_8X8
module sd_vedic_mac_seq
    import sd_mac_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   prod, p_q;
    logic                p_vld;
    logic [ACC_W-1:0]    acc_q;
    logic                ovf_q;
    logic                beat;
    logic                go;
    logic [ACC_W:0]      acc_sum;

    SD_vedic_8X8 u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    // abort gates the handshakes combinationally so it wins over a same-cycle beat
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort)
                    state_d = (len != '0) ? RUN : DONE;
            end
            RUN: begin
                in_ready = !abort;
                if (abort)
                    state_d = IDLE;
                else if (in_valid && cnt_q == LEN_W'(1))
                    state_d = DRAIN;
            end
            DRAIN: begin
                state_d = abort ? IDLE : DONE;
            end
            DONE: begin
                out_valid = !abort;
                if (abort || out_ready)
                    state_d = IDLE;
            end
        endcase
    end

    assign beat    = in_valid && in_ready;
    assign go      = (state_q == IDLE) && start && !abort;
    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(p_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            p_vld   <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
                cnt_q <= len;
            end else if (p_vld && !abort) begin
                acc_q <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W])
                    ovf_q <= 1'b1;
            end
            if (beat) begin
                p_q   <= prod;
                p_vld <= 1'b1;
                cnt_q <= cnt_q - LEN_W'(1);
            end else begin
                p_vld <= 1'b0;
            end
        end
    end

    assign acc_out  = acc_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sd_vedic_mac_seq.sv
// tb/tb_sd_vedic_mac_seq.sv - scoreboard bench for sd_vedic_mac_seq (ACC_W 24 and 16 side by side)
module tb_sd_vedic_mac_seq;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [LW-1:0] len = '0;
    logic [7:0]    a = '0;
    logic [7:0]    b = '0;

    logic        ir24, ov24, of24, bz24;
    logic [23:0] acc24;
    logic        ir16, ov16, of16, bz16;
    logic [15:0] acc16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = -100;
    int last_beat = -100;
    bit prev_ov = 1'b0;

    longint exp24_q[$];
    longint exp16_q[$];
    bit     eo24_q[$];
    bit     eo16_q[$];
    int     qa[$];
    int     qb[$];

    sd_vedic_mac_seq #(.LEN_W(LW), .ACC_W(24)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(ir24), .a(a), .b(b),
        .out_valid(ov24), .out_ready(out_ready), .acc_out(acc24),
        .overflow(of24), .busy(bz24)
    );

    sd_vedic_mac_seq #(.LEN_W(LW), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(ir16), .a(a), .b(b),
        .out_valid(ov16), .out_ready(out_ready), .acc_out(acc16),
        .overflow(of16), .busy(bz16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (start && !bz24 && !abort) last_start = cyc;
            if (in_valid && ir24) last_beat = cyc;
            if (ov24 && !prev_ov)
                chk("latency", cyc, (last_beat > last_start) ? last_beat + 2 : last_start + 1);
            if (ov24) begin
                chk("in_ready_in_done", ir24, 0);
                if (exp24_q.size() == 0) begin
                    fail_now("unexpected_result24");
                end else begin
                    chk("acc24", acc24, exp24_q[0]);
                    chk("ovf24", of24, eo24_q[0]);
                    if (out_ready) begin
                        void'(exp24_q.pop_front());
                        void'(eo24_q.pop_front());
                    end
                end
            end
            if (ov16) begin
                if (exp16_q.size() == 0) begin
                    fail_now("unexpected_result16");
                end else begin
                    chk("acc16", acc16, exp16_q[0]);
                    chk("ovf16", of16, eo16_q[0]);
                    if (out_ready) begin
                        void'(exp16_q.pop_front());
                        void'(eo16_q.pop_front());
                    end
                end
            end
        end
        prev_ov = rst_n ? ov24 : 1'b0;
    end

    task automatic burst(input int n, input bit gaps, input int hold);
        longint total;
        int     guard;
        bit     ok;
        bit     ir_seen;
        total = 0;
        for (int i = 0; i < n; i++) total += longint'(qa[i] * qb[i]);
        exp24_q.push_back(total % (longint'(1) << 24));
        eo24_q.push_back(total >= (longint'(1) << 24));
        exp16_q.push_back(total % 65536);
        eo16_q.push_back(total >= 65536);
        out_ready = (hold == 0);
        start = 1'b1;
        len = n[LW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            a = qa[i][7:0];
            b = qb[i][7:0];
            guard = 0;
            do begin
                @(negedge clk);
                ok = ir24;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < 50);
            if (!ok) fail_now("beat_timeout");
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!ov24 && guard < 50);
            if (!ov24) fail_now("out_valid_timeout");
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        guard = 0;
        ir_seen = 1'b0;
        do begin
            @(negedge clk);
            ir_seen |= ir24;
            guard++;
        end while (bz24 && guard < 100);
        if (bz24) fail_now("busy_timeout");
        if (n == 0) chk("len0_in_ready", ir_seen, 0);
        qa.delete();
        qb.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_acc24"}, acc24, 0);
        chk({tag, "_acc16"}, acc16, 0);
        chk({tag, "_ov"}, {ov24, ov16}, 0);
        chk({tag, "_ir"}, {ir24, ir16}, 0);
        chk({tag, "_busy"}, {bz24, bz16}, 0);
        chk({tag, "_ovf"}, {of24, of16}, 0);
    endtask

    initial begin
        #12;
        check_idle_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back burst with a full-scale product
        qa = '{255, 2, 0}; qb = '{255, 3, 77};
        burst(3, 1'b0, 0);

        // zero-length burst
        burst(0, 1'b0, 0);

        // gapped input, consumer stalls five cycles
        qa = '{16, 16, 16, 16}; qb = '{16, 16, 16, 16};
        burst(4, 1'b1, 5);

        // 16-bit accumulator wraps and flags overflow, next burst clears it
        qa = '{255, 255}; qb = '{255, 255};
        burst(2, 1'b0, 0);
        qa = '{1}; qb = '{1};
        burst(1, 1'b0, 0);

        // asynchronous reset mid-burst
        start = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; a = 8'd7; b = 8'd9;
        @(posedge clk); #1;
        a = 8'd3; b = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        exp24_q.delete(); eo24_q.delete(); exp16_q.delete(); eo16_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        qa = '{4}; qb = '{5};
        burst(1, 1'b0, 0);

        // start pulses during RUN are ignored, abort cancels with no result
        start = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; len = 8'd2;
            in_valid = 1'b1; a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", {bz24, bz16}, 0);
        chk("abort_in_ready", ir24, 0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", bz24, 0);
        @(posedge clk); #1;
        qa = '{10, 20, 30}; qb = '{3, 2, 1};
        burst(3, 1'b0, 0);

        // randomized bursts
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                qa.push_back($urandom_range(0, 255));
                qb.push_back($urandom_range(0, 255));
            end
            burst(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        if (exp24_q.size() != 0 || exp16_q.size() != 0) fail_now("results_missing");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

endmodule
